// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for one NCO channel: soft amplitude ramp-up, stepped
// frequency sweep (single / sawtooth / triangle), then soft ramp-down.
module nco_sweep_ctrl #(
  parameter int RAMP_DIV = 256,
  parameter int DWELL_W  = 24
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        cfg_f_start,
  input  logic [31:0]        cfg_f_stop,
  input  logic [31:0]        cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [7:0]         cfg_aul,
  output logic [31:0]        para_freq,
  output logic [7:0]         para_aul,
  output logic               busy,
  output logic               step_tick,
  output logic               done,
  output logic               cfg_err
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;

  typedef enum logic [1:0] {IDLE, RAMP_UP, SWEEP, RAMP_DOWN} state_t;

  state_t             state, state_n;
  logic               dir, dir_n;          // 0 = up, 1 = down
  logic [RW-1:0]      ramp_cnt, ramp_cnt_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [31:0]        freq_n;
  logic [7:0]         aul_n;
  logic               step_tick_n, done_n, cfg_err_n, load;

  logic [31:0]        f_start_l, f_stop_l, f_step_l;
  logic [DWELL_W-1:0] dwell_l, dwell_eff;
  logic [1:0]         mode_l;
  logic [7:0]         aul_l;

  // Saturating add/sub done in 33 bits so neither direction can wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, lim} + {1'b0, b};
    return ({1'b0, a} < s) ? lim : (a - b);
  endfunction

  assign dwell_eff = (dwell_l == '0) ? DWELL_W'(1) : dwell_l;

  always_ff @(posedge CLOCK) begin
    if (load) begin
      f_start_l <= cfg_f_start;
      f_stop_l  <= cfg_f_stop;
      f_step_l  <= cfg_f_step;
      dwell_l   <= cfg_dwell;
      mode_l    <= cfg_mode;
      aul_l     <= cfg_aul;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      ramp_cnt  <= '0;
      dwell_cnt <= '0;
      para_freq <= '0;
      para_aul  <= '0;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      ramp_cnt  <= ramp_cnt_n;
      dwell_cnt <= dwell_cnt_n;
      para_freq <= freq_n;
      para_aul  <= aul_n;
      busy      <= (state_n != IDLE);
      step_tick <= step_tick_n;
      done      <= done_n;
      cfg_err   <= cfg_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    ramp_cnt_n  = ramp_cnt;
    dwell_cnt_n = dwell_cnt;
    freq_n      = para_freq;
    aul_n       = para_aul;
    step_tick_n = 1'b0;
    done_n      = 1'b0;
    cfg_err_n   = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        aul_n = '0;
        if (start && !stop) begin
          if ((cfg_f_start > cfg_f_stop) || (cfg_f_step == '0)) begin
            cfg_err_n = 1'b1;
          end else begin
            load        = 1'b1;
            freq_n      = cfg_f_start;
            dir_n       = 1'b0;
            ramp_cnt_n  = '0;
            dwell_cnt_n = '0;
            state_n     = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (stop) begin
          state_n    = RAMP_DOWN;
          ramp_cnt_n = '0;
        end else if (para_aul == aul_l) begin
          state_n     = SWEEP;
          dwell_cnt_n = '0;
          ramp_cnt_n  = '0;
        end else if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt_n = '0;
          aul_n      = para_aul + 8'd1;
        end else begin
          ramp_cnt_n = ramp_cnt + RW'(1);
        end
      end
      SWEEP: begin
        if (stop) begin
          state_n    = RAMP_DOWN;
          ramp_cnt_n = '0;
        end else if ((dwell_cnt + DWELL_W'(1)) >= dwell_eff) begin
          dwell_cnt_n = '0;
          if (!dir) begin
            if (para_freq < f_stop_l) begin
              freq_n      = sat_add(para_freq, f_step_l, f_stop_l);
              step_tick_n = 1'b1;
            end else if (mode_l == MODE_SAW) begin
              freq_n      = f_start_l;
              step_tick_n = 1'b1;
            end else if (mode_l == MODE_TRI) begin
              dir_n       = 1'b1;
              freq_n      = sat_sub(f_stop_l, f_step_l, f_start_l);
              step_tick_n = 1'b1;
            end else begin
              state_n    = RAMP_DOWN;
              ramp_cnt_n = '0;
            end
          end else begin
            step_tick_n = 1'b1;
            if (para_freq > f_start_l) begin
              freq_n = sat_sub(para_freq, f_step_l, f_start_l);
            end else begin
              dir_n  = 1'b0;
              freq_n = sat_add(f_start_l, f_step_l, f_stop_l);
            end
          end
        end else begin
          dwell_cnt_n = dwell_cnt + DWELL_W'(1);
        end
      end
      RAMP_DOWN: begin
        if (para_aul == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt_n = '0;
          aul_n      = para_aul - 8'd1;
          if (para_aul == 8'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          ramp_cnt_n = ramp_cnt + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with RAMP_DIV=2; expected values hand-derived.
module tb_nco_sweep_ctrl;

  logic        CLOCK = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
  logic [23:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_aul = '0;
  logic [31:0] para_freq;
  logic [7:0]  para_aul;
  logic        busy, step_tick, done, cfg_err;

  int n_assert = 0;
  int n_fail = 0;

  nco_sweep_ctrl #(.RAMP_DIV(2), .DWELL_W(24)) dut (
    .CLOCK(CLOCK), .rst(rst), .start(start), .stop(stop),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_aul(cfg_aul),
    .para_freq(para_freq), .para_aul(para_aul), .busy(busy),
    .step_tick(step_tick), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [23:0] dw, input logic [1:0] md, input logic [7:0] au);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_mode = md; cfg_aul = au;
  endtask

  logic [31:0] tri_seq [8];
  logic [31:0] saw_seq [4];

  initial begin
    tri_seq = '{32'd1100, 32'd1200, 32'd1250, 32'd1150, 32'd1050, 32'd1000, 32'd1100, 32'd1200};
    saw_seq = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};

    // reset
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_freq", para_freq, 32'd0);
    check("rst_aul", {24'd0, para_aul}, 32'd0);
    check("rst_flags", {28'd0, busy, step_tick, done, cfg_err}, 32'd0);

    // 1: single sweep with ramps
    set_cfg(32'd1000, 32'd1200, 32'd100, 24'd3, 2'd0, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(32'd9, 32'd9, 32'd9, 24'd9, 2'd1, 8'd9);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_freq0", para_freq, 32'd1000);
    check("t1_aul0", {24'd0, para_aul}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t1_rampup", {24'd0, para_aul}, k / 2);
    end
    tick();
    check("t1_sweep_aul", {24'd0, para_aul}, 32'd4);
    tick(2);
    check("t1_pre_tick", {31'd0, step_tick}, 32'd0);
    check("t1_pre_freq", para_freq, 32'd1000);
    tick();
    check("t1_tick1", {31'd0, step_tick}, 32'd1);
    check("t1_freq1", para_freq, 32'd1100);
    tick();
    check("t1_tick1_off", {31'd0, step_tick}, 32'd0);
    tick(2);
    check("t1_tick2", {31'd0, step_tick}, 32'd1);
    check("t1_freq2", para_freq, 32'd1200);
    tick(3);
    check("t1_end_tick", {31'd0, step_tick}, 32'd0);
    check("t1_end_freq", para_freq, 32'd1200);
    check("t1_end_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t1_rampdn", {24'd0, para_aul}, 4 - k / 2);
      check("t1_done", {31'd0, done}, (k == 8) ? 32'd1 : 32'd0);
      check("t1_busy_dn", {31'd0, busy}, (k == 8) ? 32'd0 : 32'd1);
    end
    tick();
    check("t1_done_off", {31'd0, done}, 32'd0);
    check("t1_idle_freq", para_freq, 32'd1200);

    // 4: rejected starts
    set_cfg(32'd2000, 32'd1000, 32'd100, 24'd1, 2'd0, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err", {31'd0, cfg_err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_freq", para_freq, 32'd1200);
    tick();
    check("t4_err_off", {31'd0, cfg_err}, 32'd0);
    set_cfg(32'd1000, 32'd2000, 32'd0, 24'd1, 2'd0, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_step0", {31'd0, cfg_err}, 32'd1);
    check("t4_busy_step0", {31'd0, busy}, 32'd0);

    // 2: triangle, dwell 1, aul 0
    tick();
    set_cfg(32'd1000, 32'd1250, 32'd100, 24'd1, 2'd2, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_freq0", para_freq, 32'd1000);
    tick();
    check("t2_sweep_entry", para_freq, 32'd1000);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t2_tri", para_freq, tri_seq[k]);
      check("t2_tick", {31'd0, step_tick}, 32'd1);
      check("t2_aul", {24'd0, para_aul}, 32'd0);
    end
    stop = 1'b1;
    tick();
    check("t2_stop_freq", para_freq, 32'd1200);
    check("t2_stop_busy", {31'd0, busy}, 32'd1);
    tick();
    stop = 1'b0;
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: sawtooth across the full 32-bit range
    set_cfg(32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 24'd2, 2'd1, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_freq0", para_freq, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_mid_tick", {31'd0, step_tick}, 32'd0);
      tick();
      check("t3_saw", para_freq, saw_seq[k]);
      check("t3_tick", {31'd0, step_tick}, 32'd1);
    end
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    check("t3_done", {31'd0, done}, 32'd1);

    // 5: mid-sweep abort, then start+stop together in IDLE
    set_cfg(32'd1000, 32'd5000, 32'd100, 24'd4, 2'd0, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(9);
    tick(4);
    check("t5_freq1", para_freq, 32'd1100);
    tick(2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_dn_freq", para_freq, 32'd1100);
    check("t5_dn_aul", {24'd0, para_aul}, 32'd4);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t5_rampdn", {24'd0, para_aul}, 4 - k / 2);
      check("t5_frozen", para_freq, 32'd1100);
      check("t5_done", {31'd0, done}, (k == 8) ? 32'd1 : 32'd0);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    check("t5_ss_busy", {31'd0, busy}, 32'd0);
    check("t5_ss_err", {31'd0, cfg_err}, 32'd0);
    check("t5_ss_freq", para_freq, 32'd1100);
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("t5_ss_busy2", {31'd0, busy}, 32'd0);

    // 6: asynchronous reset mid-sweep, then a clean restart
    set_cfg(32'd1000, 32'd1250, 32'd100, 24'd1, 2'd2, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    tick();
    check("t6_pre_freq", para_freq, 32'd1100);
    #3 rst = 1'b1;
    #1;
    check("t6_async_freq", para_freq, 32'd0);
    check("t6_async_aul", {24'd0, para_aul}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_done", {31'd0, done}, 32'd0);
    set_cfg(32'd1000, 32'd1200, 32'd100, 24'd1, 2'd0, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_restart_freq", para_freq, 32'd1000);
    check("t6_restart_busy", {31'd0, busy}, 32'd1);
    tick(3);
    check("t6_aul", {24'd0, para_aul}, 32'd1);
    tick();
    check("t6_freq1", para_freq, 32'd1100);
    tick();
    check("t6_freq2", para_freq, 32'd1200);
    tick(3);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_aul_end", {24'd0, para_aul}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
